// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x DATA_WIDTH register file, 1 sync write, 2 registered reads.
// Define REGFILE_WRITE_BYPASS_EN for write-first forwarding on the read ports.
module regfile_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re0,
  input  logic [ADDR_WIDTH-1:0] rd_addr0,
  output logic [DATA_WIDTH-1:0] rd_data0,
  output logic                  rd_valid0,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic                  rd_valid1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_next0;
  logic [DATA_WIDTH-1:0] rd_next1;
  logic                  wr_ok;
  logic                  zero_rd0;
  logic                  zero_rd1;

  // Writes to the hardwired-zero entry are dropped; clr wins over we.
  assign wr_ok = we && !clr &&
                 !((ZERO_REG != 0) && (wr_addr == '0));

  assign zero_rd0 = (ZERO_REG != 0) && (rd_addr0 == '0);
  assign zero_rd1 = (ZERO_REG != 0) && (rd_addr1 == '0);

  // Storage: async reset, sync clear, then write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Port 0 read value selection (optionally write-first).
  always_comb begin
    rd_next0 = mem[rd_addr0];
    if (zero_rd0) rd_next0 = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (clr) begin
      rd_next0 = '0;
    end else if (wr_ok && (rd_addr0 == wr_addr)) begin
      rd_next0 = wr_data;
    end
`endif
  end

  // Port 1 read value selection (optionally write-first).
  always_comb begin
    rd_next1 = mem[rd_addr1];
    if (zero_rd1) rd_next1 = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (clr) begin
      rd_next1 = '0;
    end else if (wr_ok && (rd_addr1 == wr_addr)) begin
      rd_next1 = wr_data;
    end
`endif
  end

  // Port 0 output register; data holds when not enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data0  <= '0;
      rd_valid0 <= 1'b0;
    end else begin
      rd_valid0 <= re0;
      if (re0) rd_data0 <= rd_next0;
    end
  end

  // Port 1 output register; data holds when not enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data1  <= '0;
      rd_valid1 <= 1'b0;
    end else begin
      rd_valid1 <= re1;
      if (re1) rd_data1 <= rd_next1;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed scoreboard bench for regfile_2r1w.
// Instance a has ZERO_REG=1, instance b has ZERO_REG=0; both share inputs.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr;
  logic        we;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        re0;
  logic [2:0]  rd_addr0;
  logic        re1;
  logic [2:0]  rd_addr1;

  logic [31:0] a_d0, a_d1, b_d0, b_d1;
  logic        a_v0, a_v1, b_v0, b_v1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile_2r1w #(
    .DATA_WIDTH(32), .ADDR_WIDTH(3), .ZERO_REG(1)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .re0(re0), .rd_addr0(rd_addr0),
    .rd_data0(a_d0), .rd_valid0(a_v0),
    .re1(re1), .rd_addr1(rd_addr1),
    .rd_data1(a_d1), .rd_valid1(a_v1)
  );

  regfile_2r1w #(
    .DATA_WIDTH(32), .ADDR_WIDTH(3), .ZERO_REG(0)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .re0(re0), .rd_addr0(rd_addr0),
    .rd_data0(b_d0), .rd_valid0(b_v0),
    .re1(re1), .rd_addr1(rd_addr1),
    .rd_data1(b_d1), .rd_valid1(b_v1)
  );

  function automatic logic [31:0] obs(int sel);
    case (sel)
      0: return a_d0;
      1: return {31'b0, a_v0};
      2: return a_d1;
      3: return {31'b0, a_v1};
      4: return b_d0;
      5: return {31'b0, b_v0};
      6: return b_d1;
      default: return {31'b0, b_v1};
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push_inst(string tag, int inst,
                           logic [31:0] d0, logic v0,
                           logic [31:0] d1, logic v1);
    string p;
    p = (inst == 0) ? "a" : "b";
    sb.push_back('{{tag, ".", p, ".d0"}, inst*4 + 0, d0});
    sb.push_back('{{tag, ".", p, ".v0"}, inst*4 + 1, {31'b0, v0}});
    sb.push_back('{{tag, ".", p, ".d1"}, inst*4 + 2, d1});
    sb.push_back('{{tag, ".", p, ".v1"}, inst*4 + 3, {31'b0, v1}});
  endtask

  task automatic push_both(string tag,
                           logic [31:0] d0, logic v0,
                           logic [31:0] d1, logic v1);
    push_inst(tag, 0, d0, v0, d1, v1);
    push_inst(tag, 1, d0, v0, d1, v1);
  endtask

  task automatic tick();
    sb_t s;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      chk(s.tag, obs(s.sel), s.exp);
    end
  endtask

  task automatic chk_all_zero(string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s.%0d", tag, i), obs(i), 32'h0);
  endtask

  task automatic drv(logic c, logic w, logic [2:0] wa, logic [31:0] wd,
                     logic r0, logic [2:0] a0, logic r1, logic [2:0] a1);
    clr = c; we = w; wr_addr = wa; wr_data = wd;
    re0 = r0; rd_addr0 = a0; re1 = r1; rd_addr1 = a1;
  endtask

  initial begin
    reset_n = 1'b1;
    drv(0, 1, 3'd5, 32'hffffffff, 1, 3'd5, 1, 3'd5);
    #1 reset_n = 1'b0;
    #3 chk_all_zero("rst_async");
    @(posedge clk); #1;
    chk_all_zero("rst_edge");

    reset_n = 1'b1;
    drv(0, 0, 3'd0, 32'h0, 1, 3'd5, 0, 3'd0);
    push_both("rst_rd5", 32'h0, 1, 32'h0, 0);
    tick();

    drv(0, 1, 3'd1, 32'haabbccdd, 0, 3'd0, 0, 3'd0);
    push_both("wr1", 32'h0, 0, 32'h0, 0);
    tick();
    drv(0, 1, 3'd2, 32'h11223344, 0, 3'd0, 0, 3'd0);
    push_both("wr2", 32'h0, 0, 32'h0, 0);
    tick();
    drv(0, 0, 3'd0, 32'h0, 1, 3'd1, 1, 3'd2);
    push_both("rd12", 32'haabbccdd, 1, 32'h11223344, 1);
    tick();

    drv(0, 1, 3'd1, 32'h99887766, 0, 3'd1, 0, 3'd2);
    push_both("hold", 32'haabbccdd, 0, 32'h11223344, 0);
    tick();
    drv(0, 0, 3'd0, 32'h0, 1, 3'd1, 0, 3'd2);
    push_both("rd1new", 32'h99887766, 1, 32'h11223344, 0);
    tick();

    drv(0, 1, 3'd0, 32'habcdef12, 0, 3'd0, 0, 3'd0);
    push_both("wr0", 32'h99887766, 0, 32'h11223344, 0);
    tick();
    drv(0, 0, 3'd0, 32'h0, 1, 3'd0, 1, 3'd0);
    push_inst("rd0", 0, 32'h0, 1, 32'h0, 1);
    push_inst("rd0", 1, 32'habcdef12, 1, 32'habcdef12, 1);
    tick();

    drv(0, 1, 3'd3, 32'h11883366, 0, 3'd0, 0, 3'd0);
    push_inst("wr3", 0, 32'h0, 0, 32'h0, 0);
    push_inst("wr3", 1, 32'habcdef12, 0, 32'habcdef12, 0);
    tick();
    drv(0, 1, 3'd3, 32'hdeadbeef, 1, 3'd3, 1, 3'd1);
    push_both("coll", BYP ? 32'hdeadbeef : 32'h11883366, 1,
              32'h99887766, 1);
    tick();
    drv(0, 0, 3'd0, 32'h0, 1, 3'd3, 0, 3'd1);
    push_both("coll_after", 32'hdeadbeef, 1, 32'h99887766, 0);
    tick();

    drv(1, 1, 3'd4, 32'h55555555, 1, 3'd3, 1, 3'd1);
    push_both("clr_rd", BYP ? 32'h0 : 32'hdeadbeef, 1,
              BYP ? 32'h0 : 32'h99887766, 1);
    tick();
    drv(0, 0, 3'd0, 32'h0, 1, 3'd4, 1, 3'd3);
    push_both("clr_43", 32'h0, 1, 32'h0, 1);
    tick();
    drv(0, 0, 3'd0, 32'h0, 1, 3'd1, 1, 3'd2);
    push_both("clr_12", 32'h0, 1, 32'h0, 1);
    tick();
    drv(0, 0, 3'd0, 32'h0, 1, 3'd0, 1, 3'd0);
    push_both("clr_00", 32'h0, 1, 32'h0, 1);
    tick();

    drv(0, 1, 3'd6, 32'h12345678, 1, 3'd2, 0, 3'd0);
    push_both("wr6", 32'h0, 1, 32'h0, 0);
    tick();
    drv(0, 0, 3'd0, 32'h0, 1, 3'd6, 1, 3'd6);
    push_both("rd6", 32'h12345678, 1, 32'h12345678, 1);
    tick();

    drv(0, 1, 3'd7, 32'hffffffff, 1, 3'd6, 1, 3'd6);
    #3 reset_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(posedge clk); #1;
    reset_n = 1'b1;
    drv(0, 0, 3'd0, 32'h0, 1, 3'd6, 1, 3'd7);
    push_both("post_rst", 32'h0, 1, 32'h0, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
